bus_transfer_sequencer: RTL and testbench
=========================================

// Module: bus_transfer_sequencer
// PURPOSE
//   Sequences register transfers over the shared 32-bit datapath bus by driving the 5-bit bus mux select
//   and the matching register load enables. Accepts one transfer request at a time (valid/ready) and
//   runs it as a MOVE (1 bus cycle), ALU (3 bus cycles) or ALU_WIDE (4 bus cycles, Z pair -> LO/HI).
//   Sits between the control unit / testbench stimulus and the bus mux + register file enables.
// PARAMETERS
//   CODE_ZHIGH  18  bus select code of Zhigh
//   CODE_ZLOW   19  bus select code of Zlow
//   SRC_MAX     23  highest legal source select code
//   OP_W        5   ALU opcode width
// PORTS
//   clock      in   1     rising-edge clock (single clock domain)
//   clear      in   1     synchronous, active-high reset
//   req_valid  in   1     request present
//   req_ready  out  1     sequencer can accept; request taken when req_valid & req_ready at clock edge
//   req_kind   in   2     0 MOVE, 1 ALU, 2 ALU_WIDE, 3 illegal
//   req_src_a  in   5     source code (MOVE source / ALU operand A)
//   req_src_b  in   5     ALU operand B code (ignored for MOVE)
//   req_dst    in   5     destination: 0-15 R0-R15, 16 HI, 17 LO, 20 PC, 21 MDR (ignored for ALU_WIDE)
//   req_op     in   OP_W  ALU opcode (ignored for MOVE)
//   bus_code   out  5     bus mux select
//   reg_in     out  16    one-hot load enable R0-R15
//   hi_in, lo_in, pc_in, mdr_in  out 1 each  load enables
//   y_in, z_in out  1     Y / Z register load enables
//   alu_op     out  OP_W  ALU opcode, nonzero only in T_B
//   done       out  1     one-cycle pulse in final transfer cycle of a legal request
//   error      out  1     one-cycle pulse for an illegal request
// BEHAVIOUR
//   - States: IDLE, MOVE, T_A, T_B, T_ZL, T_LO, T_HI, ERR. req_ready = (state==IDLE) only.
//   - Accept cycle latches all req_* fields; the first sequence state starts on the next cycle.
//   - Outputs are decoded only from state + latched fields; no combinational path req_* -> outputs.
//   - IDLE/ERR: bus_code=0, all enables 0, alu_op=0.
//   - MOVE:  bus_code=src_a, dst enable=1, done=1 -> IDLE.
//   - ALU:   T_A bus_code=src_a, y_in=1 -> T_B bus_code=src_b, alu_op=op, z_in=1
//            -> T_ZL bus_code=CODE_ZLOW, dst enable=1, done=1 -> IDLE.
//   - ALU_WIDE: T_A, T_B as ALU -> T_LO bus_code=CODE_ZLOW, lo_in=1 -> T_HI bus_code=CODE_ZHIGH,
//            hi_in=1, done=1 -> IDLE.
//   - At most one load enable (reg_in/hi/lo/pc/mdr/y/z) is high in any cycle.
//   - Illegal at accept: kind==3; src_a>SRC_MAX; src_b>SRC_MAX for ALU/ALU_WIDE; dst not in
//     {0-15,16,17,20,21} for MOVE/ALU. Illegal -> ERR for one cycle: error=1, no enables, no done -> IDLE.
//   - MOVE with src_a==dst is legal (rewrite). req_valid while busy is ignored, not queued.
//   - Throughput: MOVE 1 per 2 cycles, ALU 1 per 4, ALU_WIDE 1 per 5 (IDLE cycle between requests).
//   - clear (any state, incl. mid-sequence): next edge -> IDLE, latched fields 0, all outputs 0
//     except req_ready=1; aborted sequence gives no done; clear beats a same-cycle req_valid.
// TESTING
//   - clear, MOVE src=5 dst=12 -> next cycle bus_code=5, reg_in=16'h1000, done=1; following cycle req_ready=1.
//   - ALU a=2 b=3 dst=7 op=3 -> y_in@bus 2; z_in,alu_op=3@bus 3; reg_in=16'h0080@bus 19 with done.
//   - ALU_WIDE a=4 b=6 -> y_in@4, z_in@6, lo_in@19, hi_in+done@18; reg_in stays 0 throughout.
//   - MOVE dst=22, then kind=3, then ALU src_b=25 -> error pulse each, zero enables, no done.
//   - clear asserted in T_B of ALU -> next cycle all enables 0, req_ready=1, done never pulses.
//   - req_valid held high across an ALU run with new fields -> second request accepted only in IDLE.

Source files
------------

// File: rtl/bus_transfer_sequencer.sv
// Register-transfer sequencer: drives the shared bus select and the register load enables
// for MOVE / ALU / ALU_WIDE requests accepted one at a time over valid/ready.
module bus_transfer_sequencer #(
    parameter int CODE_ZHIGH = 18,
    parameter int CODE_ZLOW  = 19,
    parameter int SRC_MAX    = 23,
    parameter int OP_W       = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [4:0]      req_src_a,
    input  logic [4:0]      req_src_b,
    input  logic [4:0]      req_dst,
    input  logic [OP_W-1:0] req_op,
    output logic [4:0]      bus_code,
    output logic [15:0]     reg_in,
    output logic            hi_in,
    output logic            lo_in,
    output logic            pc_in,
    output logic            mdr_in,
    output logic            y_in,
    output logic            z_in,
    output logic [OP_W-1:0] alu_op,
    output logic            done,
    output logic            error
);

    localparam logic [4:0] L_ZHIGH   = 5'(CODE_ZHIGH);
    localparam logic [4:0] L_ZLOW    = 5'(CODE_ZLOW);
    localparam logic [4:0] L_SRC_MAX = 5'(SRC_MAX);
    localparam logic [1:0] K_MOVE = 2'd0;
    localparam logic [1:0] K_WIDE = 2'd2;
    localparam logic [1:0] K_ILL  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_T_A, S_T_B, S_T_ZL, S_T_LO, S_T_HI, S_ERR
    } state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_kind;
    logic [4:0]      r_src_a, r_src_b, r_dst;
    logic [OP_W-1:0] r_op;

    logic w_accept, w_dst_ok, w_illegal, w_dst_load;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_dst_ok = (req_dst <= 5'd17) || (req_dst == 5'd20) || (req_dst == 5'd21);
    // Legality is judged on the live request only at accept; afterwards only latched fields matter.
    assign w_illegal = (req_kind == K_ILL)
                    || (req_src_a > L_SRC_MAX)
                    || ((req_kind != K_MOVE) && (req_src_b > L_SRC_MAX))
                    || ((req_kind != K_WIDE) && !w_dst_ok);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_kind  <= '0;
            r_src_a <= '0;
            r_src_b <= '0;
            r_dst   <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_kind  <= req_kind;
                r_src_a <= req_src_a;
                r_src_b <= req_src_b;
                r_dst   <= req_dst;
                r_op    <= req_op;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_illegal)             w_next = S_ERR;
                    else if (req_kind == K_MOVE) w_next = S_MOVE;
                    else                       w_next = S_T_A;
                end
            end
            S_T_A:  w_next = S_T_B;
            S_T_B:  w_next = (r_kind == K_WIDE) ? S_T_LO : S_T_ZL;
            S_T_LO: w_next = S_T_HI;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        bus_code   = '0;
        reg_in     = '0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        pc_in      = 1'b0;
        mdr_in     = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        alu_op     = '0;
        done       = 1'b0;
        error      = 1'b0;
        w_dst_load = 1'b0;
        case (r_state)
            S_MOVE: begin
                bus_code   = r_src_a;
                w_dst_load = 1'b1;
                done       = 1'b1;
            end
            S_T_A: begin
                bus_code = r_src_a;
                y_in     = 1'b1;
            end
            S_T_B: begin
                bus_code = r_src_b;
                z_in     = 1'b1;
                alu_op   = r_op;
            end
            S_T_ZL: begin
                bus_code   = L_ZLOW;
                w_dst_load = 1'b1;
                done       = 1'b1;
            end
            S_T_LO: begin
                bus_code = L_ZLOW;
                lo_in    = 1'b1;
            end
            S_T_HI: begin
                bus_code = L_ZHIGH;
                hi_in    = 1'b1;
                done     = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: ;
        endcase
        // Destination decode; r_dst was range-checked at accept so exactly one enable fires.
        if (w_dst_load) begin
            if (r_dst < 5'd16) begin
                reg_in[r_dst[3:0]] = 1'b1;
            end else begin
                case (r_dst)
                    5'd16:   hi_in  = 1'b1;
                    5'd17:   lo_in  = 1'b1;
                    5'd20:   pc_in  = 1'b1;
                    5'd21:   mdr_in = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed table-driven bench for bus_transfer_sequencer plus a hand-written mid-sequence clear case.
module tb_bus_transfer_sequencer;

    logic        clk = 1'b0;
    logic        clear = 1'b0, req_valid = 1'b0, req_ready;
    logic [1:0]  req_kind = '0;
    logic [4:0]  req_src_a = '0, req_src_b = '0, req_dst = '0, req_op = '0;
    logic [4:0]  bus_code;
    logic [15:0] reg_in;
    logic        hi_in, lo_in, pc_in, mdr_in, y_in, z_in, done, error;
    logic [4:0]  alu_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_transfer_sequencer dut (
        .clock(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_src_a(req_src_a), .req_src_b(req_src_b),
        .req_dst(req_dst), .req_op(req_op), .bus_code(bus_code), .reg_in(reg_in),
        .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .mdr_in(mdr_in),
        .y_in(y_in), .z_in(z_in), .alu_op(alu_op), .done(done), .error(error)
    );

    typedef struct {
        logic        clr, vld;
        logic [1:0]  kind;
        logic [4:0]  a, b, dst, op;
        logic        rdy;
        logic [4:0]  bus;
        logic [15:0] regs;
        logic [5:0]  en;   // {hi, lo, pc, mdr, y, z}
        logic [4:0]  aop;
        logic        dn, er;
    } vec_t;

    localparam logic [5:0] N = 6'b000000, HI = 6'b100000, LO = 6'b010000, PC = 6'b001000,
                           MD = 6'b000100, Y = 6'b000010, Z = 6'b000001;

    vec_t tbl[$];

    function automatic vec_t mk(logic clr, logic vld, logic [1:0] kind, logic [4:0] a,
                                logic [4:0] b, logic [4:0] dst, logic [4:0] op, logic rdy,
                                logic [4:0] bus, logic [15:0] regs, logic [5:0] en,
                                logic [4:0] aop, logic dn, logic er);
        vec_t v;
        v.clr = clr; v.vld = vld; v.kind = kind; v.a = a; v.b = b; v.dst = dst; v.op = op;
        v.rdy = rdy; v.bus = bus; v.regs = regs; v.en = en; v.aop = aop; v.dn = dn; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] en_now();
        return {hi_in, lo_in, pc_in, mdr_in, y_in, z_in};
    endfunction

    task automatic drive(input vec_t v);
        clear = v.clr; req_valid = v.vld; req_kind = v.kind;
        req_src_a = v.a; req_src_b = v.b; req_dst = v.dst; req_op = v.op;
    endtask

    // One idle row: no request, outputs quiescent with ready high.
    function automatic vec_t idl();
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0, N, 0, 0, 0);
    endfunction

    initial begin
        int cnt_on;
        int done_seen;

        // clr vld kind a  b  dst op | rdy bus regs     en  aop dn er
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   1, 0,  16'h0000, N,  0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5, 0, 12, 0,  0, 5,  16'h1000, N,  0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 1, 2, 3, 7, 3,   0, 2,  16'h0000, Y,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 3,  16'h0000, Z,  3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 19, 16'h0080, N,  0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 2, 4, 6, 0, 5,   0, 4,  16'h0000, Y,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 6,  16'h0000, Z,  5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 19, 16'h0000, LO, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 18, 16'h0000, HI, 0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 0, 1, 0, 22, 0,  0, 0,  16'h0000, N,  0, 0, 1));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 3, 1, 2, 3, 1,   0, 0,  16'h0000, N,  0, 0, 1));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 1, 1, 25, 3, 1,  0, 0,  16'h0000, N,  0, 0, 1));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 0, 20, 0, 20, 0, 0, 20, 16'h0000, PC, 0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 0, 23, 0, 21, 0, 0, 23, 16'h0000, MD, 0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 0, 24, 0, 1, 0,  0, 0,  16'h0000, N,  0, 0, 1));
        tbl.push_back(idl());
        // clear during T_B, together with a new request: clear wins
        tbl.push_back(mk(0, 1, 1, 2, 3, 5, 1,   0, 2,  16'h0000, Y,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 3,  16'h0000, Z,  1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 5, 0, 12, 0,  1, 0,  16'h0000, N,  0, 0, 0));
        tbl.push_back(idl());
        // req_valid held through an ALU run with different fields
        tbl.push_back(mk(0, 1, 1, 2, 3, 7, 3,   0, 2,  16'h0000, Y,  0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5, 0, 12, 0,  0, 3,  16'h0000, Z,  3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5, 0, 12, 0,  0, 19, 16'h0080, N,  0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 5, 0, 12, 0,  1, 0,  16'h0000, N,  0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5, 0, 12, 0,  0, 5,  16'h1000, N,  0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 0, 18, 0, 16, 0, 0, 18, 16'h0000, HI, 0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 0, 0, 0, 15, 0,  0, 0,  16'h8000, N,  0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 1, 9, 10, 17, 2, 0, 9,  16'h0000, Y,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 10, 16'h0000, Z,  2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 19, 16'h0000, LO, 0, 1, 0));
        tbl.push_back(idl());
        tbl.push_back(mk(0, 1, 0, 0, 0, 18, 0,  0, 0,  16'h0000, N,  0, 0, 1));
        tbl.push_back(idl());

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d.ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d.bus", i),   32'(bus_code),  32'(tbl[i].bus));
            chk($sformatf("row%0d.reg_in", i), 32'(reg_in),   32'(tbl[i].regs));
            chk($sformatf("row%0d.en", i),    32'(en_now()),  32'(tbl[i].en));
            chk($sformatf("row%0d.alu_op", i), 32'(alu_op),   32'(tbl[i].aop));
            chk($sformatf("row%0d.done", i),  32'(done),      32'(tbl[i].dn));
            chk($sformatf("row%0d.error", i), 32'(error),     32'(tbl[i].er));
            cnt_on = $countones({reg_in, en_now()});
            chk($sformatf("row%0d.onehot", i), 32'(cnt_on <= 1), 32'd1);
        end

        // Hand sequence: clear in T_LO of an ALU_WIDE run, then done must stay low.
        @(negedge clk);
        drive(mk(0, 1, 2, 4, 6, 0, 7, 0, 0, 0, N, 0, 0, 0));
        @(negedge clk);
        req_valid = 1'b0;
        chk("wide.t_a_y", 32'(y_in), 32'd1);
        @(negedge clk);
        chk("wide.t_b_aop", 32'(alu_op), 32'd7);
        @(negedge clk);
        chk("wide.t_lo", 32'(lo_in), 32'd1);
        chk("wide.t_lo_bus", 32'(bus_code), 32'd19);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("wide.clr_ready", 32'(req_ready), 32'd1);
        chk("wide.clr_en", 32'({reg_in, en_now()}), 32'd0);
        chk("wide.clr_bus", 32'(bus_code), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || !req_ready) done_seen++;
        end
        chk("wide.no_done_after_clr", 32'(done_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
